// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory beat signals of the load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 9, parameter int DATA_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator splitting misaligned accesses into two word beats
module load_store_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state;
  logic wr;
  logic [2:0] f3;
  logic [ADDR_W-1:0] addr, w0;
  logic [DATA_W-1:0] wd, b0, b1, wmask, rdata;
  logic [2*DATA_W-1:0] wsh, rsh;
  logic [1:0] o;
  logic [2:0] size;
  logic [7:0] mask;
  logic split, sext, busy, resp;
  always_comb begin
    o = addr[1:0];
    // stores have no unsigned forms, so 100/101 fall through to a word
    size = (f3[1:0] == 2'b00 && (!wr || !f3[2])) ? 3'd1 :
           (f3[1:0] == 2'b01 && (!wr || !f3[2])) ? 3'd2 : 3'd4;
    sext = !wr && !f3[2] && size != 3'd4;
    split = ({2'b00, o} + {1'b0, size}) > 4'd4;
    mask = 8'((size == 3'd1 ? 8'h01 : size == 3'd2 ? 8'h03 : 8'h0F) << o);
    wmask = size == 3'd1 ? DATA_W'(32'hFF) : size == 3'd2 ? DATA_W'(32'hFFFF) : '1;
    wsh = {{DATA_W{1'b0}}, wd & wmask} << {o, 3'b000};
    rsh = {b1, b0} >> {o, 3'b000};
    rdata = size == 3'd1 ? {{24{sext & rsh[7]}}, rsh[7:0]} :
            size == 3'd2 ? {{16{sext & rsh[15]}}, rsh[15:0]} : rsh[DATA_W-1:0];
    w0 = {addr[ADDR_W-1:2], 2'b00};
    busy = !reset && (state == BEAT0 || state == BEAT1);
    resp = !reset && state == RESP;
    bus.req_ready = !reset && state == IDLE;
    bus.mem_req = busy;
    bus.mem_we = busy && wr;
    bus.mem_addr = !busy ? '0 : state == BEAT1 ? w0 + ADDR_W'(4) : w0;
    bus.mem_be = !busy ? 4'h0 : state == BEAT1 ? mask[7:4] : mask[3:0];
    bus.mem_wdata = !(busy && wr) ? '0 : state == BEAT1 ? wsh[2*DATA_W-1:DATA_W] : wsh[DATA_W-1:0];
    bus.resp_valid = resp;
    bus.resp_rdata = (resp && !wr) ? rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr <= 1'b0;
      f3 <= 3'b000;
      addr <= '0;
      wd <= '0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          wr <= bus.req_write;
          f3 <= bus.req_funct3;
          addr <= bus.req_addr;
          wd <= bus.req_wdata;
          b0 <= '0;
          b1 <= '0;
          state <= BEAT0;
        end
        BEAT0: if (bus.mem_ack) begin
          b0 <= bus.mem_rdata;
          state <= split ? BEAT1 : RESP;
        end
        BEAT1: if (bus.mem_ack) begin
          b1 <= bus.mem_rdata;
          state <= RESP;
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule
